matrix_load_sequencer: RTL and testbench
========================================

Name: matrix_load_sequencer

Overview:
- Sequences the loading of per-layer weight matrices into matrix storage.
- Accepts row words from an upstream source over a valid/ready handshake.
- Issues registered write strobes with the target layer and row indices for each accepted word.
- Runs for a programmed number of layers, then reports completion. Also supports abort and reports bad configuration.

Parameters:
- SIZE, 3, rows per matrix (one layer = SIZE rows); must be ≥ 1.
- MAX_LAYERS, 4, largest legal layer count per load job.
- ROW_WIDTH, 96, width of one row word in bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a load job; sampled only in IDLE.
- num_layers  input  32  layer count for the job; sampled with start.
- abort  input  1  cancels the job in progress.
- in_valid  input  1  upstream row word valid.
- in_row  input  ROW_WIDTH  upstream row word.
- in_ready  output  1  sequencer accepts in_row this cycle.
- wr_en  output  1  storage write strobe.
- wr_layer  output  32  layer index of the write.
- wr_row  output  32  row index of the write.
- wr_data  output  ROW_WIDTH  row word to store.
- layer_index  output  32  current layer counter (next layer to be written).
- row_index  output  32  current row counter (next row to be written).
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the final row is written.
- cfg_err  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset: state=IDLE. All outputs 0: counters, wr_*, busy, done, cfg_err, in_ready.
- States are IDLE, LOAD and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start with 1 ≤ num_layers ≤ MAX_LAYERS: latch num_layers, clear layer_index/row_index, go to LOAD next cycle.
  - start with num_layers==0 or num_layers > MAX_LAYERS: cfg_err=1 the next cycle, stay in IDLE.
- LOAD:
  - busy=1. in_ready = (state==LOAD) && !abort, combinational.
  - Transfer = in_valid && in_ready.
  - On transfer, in the next cycle: wr_en=1, wr_layer/wr_row = counters before increment, wr_data = in_row. Write latency is 1 cycle.
  - Without a transfer, wr_en=0 the next cycle. wr_layer/wr_row/wr_data hold their last values.
  - Counter advance on transfer: if row_index==SIZE-1 then row_index←0 and layer_index+1; else row_index+1.
  - Transfer of row SIZE-1 of layer num_layers-1 moves the state to DONE. The counters do not advance on this transfer; they hold num_layers-1 / SIZE-1.
  - abort=1: no transfer that cycle, go to IDLE next cycle, counters hold, no done. A write already registered from the previous cycle still completes.
  - start is ignored in LOAD.
- DONE:
  - Lasts exactly one cycle. done=1 and wr_en=1 for the final row in that same cycle. busy=0, in_ready=0.
  - Then go to IDLE. start in the DONE cycle is ignored.
- Counters use 32-bit unsigned arithmetic and never exceed num_layers-1 / SIZE-1.
- Simultaneous events:
  - abort together with in_valid: abort wins, the word is not consumed.
  - reset overrides everything, at any time.
- Reset mid-LOAD: job discarded, all outputs 0 immediately (asynchronous). No done.

Test Plan:
- Basic job: SIZE=3, start with num_layers=2, in_valid held high with rows R0..R5.
  - Required: wr_en high for 6 consecutive cycles, (layer,row) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), wr_data=R0..R5.
  - done pulses with the (1,2) write; busy low the cycle after.
- Backpressure-free gaps: num_layers=1, in_valid toggling 1,0,1,0,1.
  - Required: exactly 3 writes, each 1 cycle after its transfer.
  - (0,0),(0,1),(0,2), done on the third write.
- Illegal config: start with num_layers=0, then with num_layers=5.
  - Required: cfg_err pulses once per start, busy stays 0, no wr_en.
- Abort: num_layers=2, abort asserted after 4 transfers with in_valid=1.
  - Required: in_ready=0 in the abort cycle, 4 writes total, IDLE next cycle.
  - layer_index=1, row_index=1, no done.
- Async reset mid-job: assert reset between clock edges during LOAD.
  - Required: busy, wr_en, counters = 0 before the next edge.
  - A subsequent start with num_layers=1 loads normally from (0,0).
- start while busy: pulse start with num_layers=3 during a num_layers=1 job.
  - Required: ignored, job ends after 3 writes, no cfg_err.

Source files
------------

// File: rtl/matrix_load_sequencer.sv
`default_nettype none
// ============================================================================
// matrix_load_sequencer : streams row words into per-layer matrix storage
// Rev 1.0
// ============================================================================
module matrix_load_sequencer #(
   parameter int SIZE       = 3,
   parameter int MAX_LAYERS = 4,
   parameter int ROW_WIDTH  = 96
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          num_layers,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [ROW_WIDTH-1:0] in_row,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [31:0]          wr_layer,
   output logic [31:0]          wr_row,
   output logic [ROW_WIDTH-1:0] wr_data,
   output logic [31:0]          layer_index,
   output logic [31:0]          row_index,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   localparam logic [31:0] LAST_ROW   = 32'(SIZE - 1);
   localparam logic [31:0] MAX_LAYERS_W = 32'(MAX_LAYERS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] layers_q;
   logic        transfer;
   logic        last_row;
   logic        last_layer;
   logic        cfg_ok;

   assign in_ready   = (state == S_LOAD) && !abort;
   assign transfer   = in_valid && in_ready;
   assign last_row   = (row_index == LAST_ROW);
   assign last_layer = (layer_index == (layers_q - 32'd1));
   assign cfg_ok     = (num_layers != 32'd0) && (num_layers <= MAX_LAYERS_W);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         layers_q    <= '0;
         layer_index <= '0;
         row_index   <= '0;
         wr_en       <= 1'b0;
         wr_layer    <= '0;
         wr_row      <= '0;
         wr_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         wr_en   <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     layers_q    <= num_layers;
                     layer_index <= '0;
                     row_index   <= '0;
                     busy        <= 1'b1;
                     state       <= S_LOAD;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (transfer) begin
                  wr_en    <= 1'b1;
                  wr_layer <= layer_index;
                  wr_row   <= row_index;
                  wr_data  <= in_row;
                  // The final row leaves the counters parked on the last position.
                  if (last_row && last_layer) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else if (last_row) begin
                     row_index   <= '0;
                     layer_index <= layer_index + 32'd1;
                  end else begin
                     row_index <= row_index + 32'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_load_sequencer.sv
`default_nettype none
// Testbench for matrix_load_sequencer: directed vector table, corner sequences
// and randomized traffic against a word-count reference model.
module tb_matrix_load_sequencer;

   localparam int SIZE       = 3;
   localparam int MAX_LAYERS = 4;
   localparam int ROW_WIDTH  = 96;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [31:0]          num_layers;
   logic                 abort;
   logic                 in_valid;
   logic [ROW_WIDTH-1:0] in_row;
   logic                 in_ready;
   logic                 wr_en;
   logic [31:0]          wr_layer;
   logic [31:0]          wr_row;
   logic [ROW_WIDTH-1:0] wr_data;
   logic [31:0]          layer_index;
   logic [31:0]          row_index;
   logic                 busy;
   logic                 done;
   logic                 cfg_err;

   matrix_load_sequencer #(
      .SIZE       (SIZE),
      .MAX_LAYERS (MAX_LAYERS),
      .ROW_WIDTH  (ROW_WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_layers  (num_layers),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_row      (in_row),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_layer    (wr_layer),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .layer_index (layer_index),
      .row_index   (row_index),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a job is L*SIZE words; k counts words accepted so far.
   int                   m_phase;   // 0 idle, 1 loading, 2 final-write cycle
   longint               m_L;
   longint               m_k;
   logic                 m_wr_en, m_done, m_busy, m_cfg;
   logic [31:0]          m_wl, m_wrw, m_li, m_ri;
   logic [ROW_WIDTH-1:0] m_wd;

   task automatic model_idx();
      longint total, kk;
      total = m_L * SIZE;
      kk    = (total > 0 && m_k >= total) ? total - 1 : m_k;
      m_li  = 32'(kk / SIZE);
      m_ri  = 32'(kk % SIZE);
   endtask

   task automatic model_reset();
      m_phase = 0; m_L = 0; m_k = 0;
      m_wr_en = 0; m_done = 0; m_busy = 0; m_cfg = 0;
      m_wl = 0; m_wrw = 0; m_wd = '0;
      model_idx();
   endtask

   task automatic model_step(input logic st, input logic [31:0] nl, input logic ab,
                             input logic iv, input logic [ROW_WIDTH-1:0] rw);
      m_wr_en = 0; m_done = 0; m_cfg = 0;
      case (m_phase)
         0: if (st) begin
               if (nl >= 1 && nl <= MAX_LAYERS) begin
                  m_L = longint'(nl); m_k = 0; m_phase = 1;
               end else m_cfg = 1;
            end
         1: if (ab) m_phase = 0;
            else if (iv) begin
               m_wr_en = 1;
               m_wl    = 32'(m_k / SIZE);
               m_wrw   = 32'(m_k % SIZE);
               m_wd    = rw;
               m_k++;
               if (m_k == m_L * SIZE) begin
                  m_phase = 2; m_done = 1;
               end
            end
         default: m_phase = 0;
      endcase
      m_busy = (m_phase == 1);
      model_idx();
   endtask

   task automatic check_post();
      chk("wr_en", 128'(wr_en), 128'(m_wr_en));
      chk("wr_layer", 128'(wr_layer), 128'(m_wl));
      chk("wr_row", 128'(wr_row), 128'(m_wrw));
      chk("wr_data", 128'(wr_data), 128'(m_wd));
      chk("done", 128'(done), 128'(m_done));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("cfg_err", 128'(cfg_err), 128'(m_cfg));
      chk("layer_index", 128'(layer_index), 128'(m_li));
      chk("row_index", 128'(row_index), 128'(m_ri));
   endtask

   // One clock: drive inputs, check the combinational ready, clock, check registers.
   task automatic cycle(input logic st, input logic [31:0] nl, input logic ab,
                        input logic iv, input logic [ROW_WIDTH-1:0] rw, output logic rdy);
      start = st; num_layers = nl; abort = ab; in_valid = iv; in_row = rw;
      #1;
      rdy = in_ready;
      chk("in_ready", 128'(in_ready), 128'((m_phase == 1) && !ab));
      model_step(st, nl, ab, iv, rw);
      @(posedge clk);
      #1;
      check_post();
   endtask

   function automatic logic [ROW_WIDTH-1:0] rowval(input int i);
      return {32'hDEAD_0000 + 32'(i), 32'h1234_5678 ^ 32'(i), 32'hFACE_0000 + 32'(i)};
   endfunction

   typedef struct {
      logic        st;
      logic [31:0] nl;
      logic        ab;
      logic        iv;
      int          ri;
      logic        e_rdy, e_we;
      logic [31:0] e_wl, e_wr;
      logic        e_dn, e_bs, e_cf;
      logic [31:0] e_li, e_ri;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic [31:0] nl, input logic ab,
                               input logic iv, input int ri, input logic e_rdy,
                               input logic e_we, input logic [31:0] e_wl, input logic [31:0] e_wr,
                               input logic e_dn, input logic e_bs, input logic e_cf,
                               input logic [31:0] e_li, input logic [31:0] e_ri);
      vec_t v;
      v.st = st; v.nl = nl; v.ab = ab; v.iv = iv; v.ri = ri;
      v.e_rdy = e_rdy; v.e_we = e_we; v.e_wl = e_wl; v.e_wr = e_wr;
      v.e_dn = e_dn; v.e_bs = e_bs; v.e_cf = e_cf; v.e_li = e_li; v.e_ri = e_ri;
      return v;
   endfunction

   vec_t tbl[26];

   initial begin
      logic rdy;
      int   nw, nd, nc;

      //               st nl ab iv ri  rdy we wl wr dn bs cf li ri
      tbl[0]  = mk(1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0, 0, 1);
      tbl[2]  = mk(0, 0, 0, 1, 1,  1, 1, 0, 1, 0, 1, 0, 0, 2);
      tbl[3]  = mk(0, 0, 0, 1, 2,  1, 1, 0, 2, 0, 1, 0, 1, 0);
      tbl[4]  = mk(0, 0, 0, 1, 3,  1, 1, 1, 0, 0, 1, 0, 1, 1);
      tbl[5]  = mk(0, 0, 0, 1, 4,  1, 1, 1, 1, 0, 1, 0, 1, 2);
      tbl[6]  = mk(0, 0, 0, 1, 5,  1, 1, 1, 2, 1, 0, 0, 1, 2);
      tbl[7]  = mk(0, 0, 0, 1, 6,  0, 0, 0, 0, 0, 0, 0, 1, 2);
      tbl[8]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 2);
      tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2);
      tbl[10] = mk(1, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 2);
      tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2);
      tbl[12] = mk(1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[13] = mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0, 0, 1);
      tbl[14] = mk(0, 0, 0, 1, 1,  1, 1, 0, 1, 0, 1, 0, 0, 2);
      tbl[15] = mk(0, 0, 0, 1, 2,  1, 1, 0, 2, 0, 1, 0, 1, 0);
      tbl[16] = mk(0, 0, 0, 1, 3,  1, 1, 1, 0, 0, 1, 0, 1, 1);
      tbl[17] = mk(0, 0, 1, 1, 4,  0, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[18] = mk(0, 0, 0, 1, 4,  0, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[19] = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[20] = mk(0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0, 0, 1);
      tbl[21] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 1);
      tbl[22] = mk(0, 0, 0, 1, 1,  1, 1, 0, 1, 0, 1, 0, 0, 2);
      tbl[23] = mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 0, 2);
      tbl[24] = mk(0, 0, 0, 1, 2,  1, 1, 0, 2, 1, 0, 0, 0, 2);
      tbl[25] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 2);

      reset = 1'b1; start = 0; num_layers = 0; abort = 0; in_valid = 0; in_row = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_post();
      chk("reset in_ready", 128'(in_ready), 128'(0));
      #2 reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 26; i++) begin
         cycle(tbl[i].st, tbl[i].nl, tbl[i].ab, tbl[i].iv, rowval(tbl[i].ri), rdy);
         chk($sformatf("tbl[%0d] in_ready", i), 128'(rdy), 128'(tbl[i].e_rdy));
         chk($sformatf("tbl[%0d] wr_en", i), 128'(wr_en), 128'(tbl[i].e_we));
         if (tbl[i].e_we) begin
            chk($sformatf("tbl[%0d] wr_layer", i), 128'(wr_layer), 128'(tbl[i].e_wl));
            chk($sformatf("tbl[%0d] wr_row", i), 128'(wr_row), 128'(tbl[i].e_wr));
            chk($sformatf("tbl[%0d] wr_data", i), 128'(wr_data), 128'(rowval(tbl[i].ri)));
         end
         chk($sformatf("tbl[%0d] done", i), 128'(done), 128'(tbl[i].e_dn));
         chk($sformatf("tbl[%0d] busy", i), 128'(busy), 128'(tbl[i].e_bs));
         chk($sformatf("tbl[%0d] cfg_err", i), 128'(cfg_err), 128'(tbl[i].e_cf));
         chk($sformatf("tbl[%0d] layer_index", i), 128'(layer_index), 128'(tbl[i].e_li));
         chk($sformatf("tbl[%0d] row_index", i), 128'(row_index), 128'(tbl[i].e_ri));
      end

      // Asynchronous reset between edges in the middle of a job
      cycle(1, 2, 0, 0, '0, rdy);
      cycle(0, 0, 0, 1, rowval(10), rdy);
      cycle(0, 0, 0, 1, rowval(11), rdy);
      #2 reset = 1'b1;
      #1;
      chk("async busy", 128'(busy), 128'(0));
      chk("async wr_en", 128'(wr_en), 128'(0));
      chk("async layer_index", 128'(layer_index), 128'(0));
      chk("async row_index", 128'(row_index), 128'(0));
      chk("async in_ready", 128'(in_ready), 128'(0));
      chk("async wr_data", 128'(wr_data), 128'(0));
      #2 reset = 1'b0;
      model_reset();
      cycle(1, 1, 0, 0, '0, rdy);
      for (int i = 0; i < SIZE; i++) cycle(0, 0, 0, 1, rowval(20 + i), rdy);
      chk("post-reset job done", 128'(done), 128'(1));
      cycle(0, 0, 0, 0, '0, rdy);

      // start while busy (and in the DONE cycle) must be ignored
      nw = 0; nd = 0; nc = 0;
      for (int i = 0; i < 6; i++) begin
         cycle((i == 0) || (i == 2) || (i == 4), (i == 0) ? 32'd1 : 32'd3, 0,
               (i >= 1 && i <= 4), rowval(30 + i), rdy);
         nw += int'(wr_en); nd += int'(done); nc += int'(cfg_err);
      end
      chk("busy-start writes", 128'(nw), 128'(3));
      chk("busy-start done", 128'(nd), 128'(1));
      chk("busy-start cfg_err", 128'(nc), 128'(0));
      chk("busy-start idle", 128'(busy), 128'(0));

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic        st, ab, iv;
         logic [31:0] nl;
         st = ($urandom % 6) == 0;
         nl = (($urandom % 10) == 0) ? $urandom : 32'($urandom_range(0, MAX_LAYERS + 2));
         ab = ($urandom % 20) == 0;
         iv = ($urandom % 4) != 0;
         cycle(st, nl, ab, iv, {$urandom, $urandom, $urandom}, rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
